// File: rtl/fifo_ram.sv
// Simple dual-port word store behind FIFO pointer logic; one write and one read port on clk.
// Read latency 1 cycle (rd_data updates after the edge sampling rd_en); writes take effect at the edge.
// No backpressure: always accepts both ports every cycle, so overflow/underflow is the caller's job.
module fifo_ram #(
    parameter int    DATA_WIDTH = 32,
    parameter int    ADDR_WIDTH = 4,
    parameter string SSA_EN     = "YES"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam bit BYPASS = (SSA_EN == "YES");

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] byp_q;
    logic                  byp_flag;
    logic                  collide;

    assign collide = BYPASS && wr_en && (wr_addr == rd_addr);

    // Storage is never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q     <= '0;
            byp_flag <= 1'b0;
        end else if (rd_en) begin
            rd_q     <= mem[rd_addr];
            byp_flag <= collide;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && rd_en && collide) begin
            byp_q <= wr_data;
        end
    end

    // Both mux legs and the select are registers, so no input reaches rd_data combinationally.
    assign rd_data = byp_flag ? byp_q : rd_q;

endmodule

// File: tb/tb_fifo_ram.sv
// Bench for fifo_ram: one instance per collision mode, scoreboard of expected read data.
module tb_fifo_ram;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wr_data;
    logic [3:0]  wr_addr;
    logic [3:0]  rd_addr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] rd_data_yes;
    logic [31:0] rd_data_no;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [16];
    logic [31:0] exp_yes = 32'h0;
    logic [31:0] exp_no  = 32'h0;
    logic [31:0] q_yes [$];
    logic [31:0] q_no  [$];
    string       q_tag [$];

    always #5 clk = ~clk;

    fifo_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .SSA_EN("YES")) u_yes (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_addr(wr_addr),
        .rd_addr(rd_addr), .wr_en(wr_en), .rd_en(rd_en), .rd_data(rd_data_yes)
    );

    fifo_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .SSA_EN("NO")) u_no (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_addr(wr_addr),
        .rd_addr(rd_addr), .wr_en(wr_en), .rd_en(rd_en), .rd_data(rd_data_no)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drive one cycle, predict the outcome, then compare after the edge.
    task automatic cyc(input string tag, input logic rst, input logic we, input logic [3:0] wa,
                       input logic [31:0] wd, input logic re, input logic [3:0] ra);
        @(negedge clk);
        reset   = rst;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
        if (rst) begin
            exp_yes = 32'h0;
            exp_no  = 32'h0;
        end else begin
            if (re) begin
                exp_no  = model[ra];
                exp_yes = (we && wa == ra) ? wd : model[ra];
            end
            if (we) model[wa] = wd;
        end
        q_yes.push_back(exp_yes);
        q_no.push_back(exp_no);
        q_tag.push_back(tag);
        @(posedge clk);
        #1;
        begin
            string t;
            t = q_tag.pop_front();
            check({t, "_yes"}, rd_data_yes, q_yes.pop_front());
            check({t, "_no"},  rd_data_no,  q_no.pop_front());
        end
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;

        cyc("rst0", 1, 0, 0, 0, 0, 0);
        cyc("rst1", 1, 0, 0, 0, 0, 0);
        cyc("idle0", 0, 0, 0, 0, 0, 0);
        cyc("idle1", 0, 0, 0, 0, 0, 0);

        cyc("wr3", 0, 1, 3, 32'hDEADBEEF, 0, 0);
        cyc("wr4", 0, 1, 4, 32'h12345678, 0, 0);
        cyc("rd3", 0, 0, 0, 0, 1, 3);
        cyc("rd4", 0, 0, 0, 0, 1, 4);

        cyc("rd3b", 0, 0, 0, 0, 1, 3);
        cyc("hold_wr3", 0, 1, 3, 32'hAAAA5555, 0, 0);
        cyc("hold_idle", 0, 0, 0, 0, 0, 0);
        cyc("rd3_new", 0, 0, 0, 0, 1, 3);

        cyc("wr5", 0, 1, 5, 32'h11111111, 0, 0);
        cyc("coll5", 0, 1, 5, 32'h22222222, 1, 5);
        cyc("coll_hold", 0, 0, 0, 0, 0, 0);
        cyc("rd5", 0, 0, 0, 0, 1, 5);

        cyc("coll_then_rst", 0, 1, 6, 32'h66666666, 1, 6);
        cyc("rst_rd3", 1, 0, 0, 0, 1, 3);
        cyc("rst_wr3", 1, 1, 3, 32'hBADBAD00, 1, 3);
        cyc("after_rst_idle", 0, 0, 0, 0, 0, 0);
        cyc("rd3_after_rst", 0, 0, 0, 0, 1, 3);

        for (int i = 0; i < 16; i++) cyc("fill", 0, 1, 4'(i), 32'(i), 0, 0);
        cyc("wr0_rd15", 0, 1, 0, 32'hFF, 1, 15);
        cyc("rd0", 0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 300; i++) begin
            logic [3:0] a;
            a = 4'($urandom_range(0, 15));
            cyc("rand", ($urandom_range(0, 40) == 0), $urandom_range(0, 1) == 1,
                ($urandom_range(0, 3) == 0) ? a : 4'($urandom_range(0, 15)),
                $urandom, $urandom_range(0, 1) == 1, a);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
